// File: rtl/bcd_scan_mux_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : bcd_scan_mux_pkg                                             |
// | Description : Shared constants, slot-index type and helper functions for   |
// |               the multiplexed 4-digit BCD display scanner.                 |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
package bcd_scan_mux_pkg;

  localparam int NDIG  = 4;
  localparam int DIG_W = 4;
  localparam logic [DIG_W-1:0] BCD_MAX = 4'd9;

  // Index of the digit slot currently being driven.
  typedef logic [1:0] sel_t;

  localparam sel_t SEL_LAST = 2'd3;

  // Nibble of digit s from a packed four-digit value.
  function automatic logic [DIG_W-1:0] dig_of(input logic [NDIG*DIG_W-1:0] v,
                                              input sel_t s);
    return v[int'(s)*DIG_W +: DIG_W];
  endfunction

  // True when slot s is a leading zero: not the units digit, and this digit
  // plus every more significant digit are all zero.
  function automatic logic lead_zero(input logic [NDIG*DIG_W-1:0] v,
                                     input sel_t s);
    logic z;
    z = (s != '0);
    for (int k = 0; k < NDIG; k++) begin
      if ((k >= int'(s)) && (v[k*DIG_W +: DIG_W] != '0)) begin
        z = 1'b0;
      end
    end
    return z;
  endfunction

  // True when any nibble of v lies outside the decimal range.
  function automatic logic has_err(input logic [NDIG*DIG_W-1:0] v);
    logic e;
    e = 1'b0;
    for (int k = 0; k < NDIG; k++) begin
      if (v[k*DIG_W +: DIG_W] > BCD_MAX) begin
        e = 1'b1;
      end
    end
    return e;
  endfunction

endpackage
`default_nettype wire

// File: rtl/bcd_scan_mux_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : bcd_scan_mux_if                                              |
// | Description : Load handshake and display outputs of bcd_scan_mux.          |
// |   din[15:0]  packed BCD value offered        din_valid  offer strobe       |
// |   din_ready  scanner can take a new value     bcd[3:0]   active nibble      |
// |   an[3:0]    active-low digit enables        bcd_err    non-BCD nibble     |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
interface bcd_scan_mux_if;
  import bcd_scan_mux_pkg::*;

  logic [NDIG*DIG_W-1:0] din;
  logic                  din_valid;
  logic                  din_ready;
  logic [DIG_W-1:0]      bcd;
  logic [NDIG-1:0]       an;
  logic                  bcd_err;

  modport master (output din, din_valid,
                  input  din_ready, bcd, an, bcd_err);

  modport slave  (input  din, din_valid,
                  output din_ready, bcd, an, bcd_err);

endinterface
`default_nettype wire

// File: rtl/bcd_scan_mux_scan_tick_gen.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : scan_tick_gen                                                |
// | Description : Free-running prescaler 0..CLK_DIV-1; tick is high for the   |
// |               one cycle in which the count sits at CLK_DIV-1.              |
// |   clk  system clock        rst  async active-high reset                    |
// |   tick one-cycle slot-advance strobe                                       |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module scan_tick_gen #(
  parameter int CLK_DIV = 50000
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int c_cnt_w = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(CLK_DIV - 1);

  logic [c_cnt_w-1:0] r_cnt;

  assign tick = (r_cnt == c_last);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (tick) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + c_cnt_w'(1);
    end
  end

endmodule
`default_nettype wire

// File: rtl/bcd_scan_mux.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : bcd_scan_mux                                                 |
// | Description : Time-multiplexed scanner for four BCD digits. A new value    |
// |               is held pending and only swapped into the display register  |
// |               at a frame end, so every frame shows a single value.         |
// |   clk  system clock        rst  async active-high reset                    |
// |   bus  slave side of bcd_scan_mux_if (din/din_valid/din_ready in,          |
// |        bcd/an/bcd_err out)                                                 |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module bcd_scan_mux
  import bcd_scan_mux_pkg::*;
#(
  parameter int CLK_DIV  = 50000,
  parameter int LZ_BLANK = 1
) (
  input  logic           clk,
  input  logic           rst,
  bcd_scan_mux_if.slave  bus
);

  localparam logic [NDIG-1:0] c_an_one = NDIG'(1);

  logic                  w_tick;
  logic                  w_frame_end;
  logic                  w_accept;
  logic                  w_swap;
  logic [NDIG*DIG_W-1:0] w_disp_next;
  sel_t                  w_sel_next;
  logic                  w_blank;

  sel_t                  r_sel;
  logic                  r_pend;
  logic [NDIG*DIG_W-1:0] r_pend_val;
  logic [NDIG*DIG_W-1:0] r_disp;
  logic [DIG_W-1:0]      r_bcd;
  logic [NDIG-1:0]       r_an;
  logic                  r_err;

  scan_tick_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_tick (
    .clk  (clk),
    .rst  (rst),
    .tick (w_tick)
  );

  assign w_frame_end = w_tick && (r_sel == SEL_LAST);
  assign w_accept    = bus.din_valid && !r_pend;
  assign w_swap      = w_frame_end && r_pend;

  // Slot outputs are computed from the value the display register is about
  // to hold, so slot 0 of a new frame already shows the newly swapped value.
  assign w_disp_next = w_swap ? r_pend_val : r_disp;
  assign w_sel_next  = r_sel + sel_t'(1);
  assign w_blank     = (LZ_BLANK != 0) && lead_zero(w_disp_next, w_sel_next);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sel      <= '0;
      r_pend     <= 1'b0;
      r_pend_val <= '0;
      r_disp     <= '0;
      r_bcd      <= '0;
      r_an       <= ~c_an_one;
      r_err      <= 1'b0;
    end else begin
      // Accept only happens with nothing pending, so it never collides with
      // a swap; a value taken on a frame-end edge waits for the next frame.
      if (w_accept) begin
        r_pend     <= 1'b1;
        r_pend_val <= bus.din;
      end else if (w_swap) begin
        r_pend     <= 1'b0;
      end

      if (w_tick) begin
        r_sel  <= w_sel_next;
        r_disp <= w_disp_next;
        r_err  <= has_err(w_disp_next);
        if (w_blank) begin
          r_bcd <= '0;
          r_an  <= '1;
        end else begin
          r_bcd <= dig_of(w_disp_next, w_sel_next);
          r_an  <= ~(c_an_one << w_sel_next);
        end
      end
    end
  end

  assign bus.din_ready = !r_pend;
  assign bus.bcd       = r_bcd;
  assign bus.an        = r_an;
  assign bus.bcd_err   = r_err;

endmodule
`default_nettype wire
